// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and constants for the TX and RX blocks
package uart_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;
  // parity mode: bit0 = enable, bit1 = even, bit2 = stick
  localparam logic [2:0] PAR_NONE  = 3'b000;
  localparam logic [2:0] PAR_ODD   = 3'b001;
  localparam logic [2:0] PAR_EVEN  = 3'b011;
  localparam logic [2:0] PAR_MARK  = 3'b101;
  localparam logic [2:0] PAR_SPACE = 3'b111;
  // stop-bit select; STP_TWO means 1.5 stop bits for 5-bit frames
  localparam logic STP_ONE = 1'b0;
  localparam logic STP_TWO = 1'b1;
  function automatic logic [3:0] clamp_len(input logic [3:0] len, input logic [3:0] max_len);
    return (len < 4'd5) ? 4'd5 : ((len > max_len) ? max_len : len);
  endfunction
endpackage

// File: rtl/uart_parity_gen.sv
// uart_parity_gen: parity bit of the length-masked data word for a given mode
//   data_i  data word (bits at and above len_i are ignored)
//   len_i   effective number of data bits
//   mode_i  parity mode; par_o is 0 when parity is disabled
//   par_o   parity bit to transmit / compare
module uart_parity_gen #(
  parameter int W = 9
) (
  input  logic [W-1:0] data_i,
  input  logic [3:0]   len_i,
  input  logic [2:0]   mode_i,
  output logic         par_o
);
  logic [W-1:0] masked;
  logic         x;
  always_comb begin
    masked = '0;
    for (int i = 0; i < W; i++) masked[i] = data_i[i] & (4'(i) < len_i);
    x = ^masked;
    par_o = mode_i[0] & (mode_i[2] ? ~mode_i[1] : (mode_i[1] ? x : ~x));
  end
endmodule

// File: rtl/uart_tx_ext.sv
// uart_tx_ext: UART transmitter with configurable length, parity, stop bits, order and break
//   uart_clk_i/uart_rst_i  clock, async active-high reset
//   tx_clk_en_i            OVS x baud tick
//   tx_fifo_*              show-ahead FIFO head, empty flag, one-cycle pop
//   data_len_i, par_mode_i, stp_bits_i, msb_first_i  frame config, latched at fetch
//   brk_i                  holds the line low, blocks fetches
//   tsr_empty_o            no frame in progress
//   uart_tx_o              registered serial line, idle high
module uart_tx_ext
  import uart_pkg::*;
#(
  parameter int MAX_DATA_W = 9,
  parameter int OVS        = 16
) (
  input  logic                  uart_clk_i,
  input  logic                  uart_rst_i,
  input  logic                  tx_clk_en_i,
  input  logic [MAX_DATA_W-1:0] tx_fifo_data_i,
  input  logic                  tx_fifo_empty_i,
  output logic                  tx_fifo_rd_en_o,
  input  logic [3:0]            data_len_i,
  input  logic [2:0]            par_mode_i,
  input  logic                  stp_bits_i,
  input  logic                  msb_first_i,
  input  logic                  brk_i,
  output logic                  tsr_empty_o,
  output logic                  uart_tx_o
);
  localparam int CW = $clog2(2 * OVS);
  localparam logic [CW-1:0] T_BIT   = CW'(OVS - 1);
  localparam logic [CW-1:0] T_STP15 = CW'(OVS * 3 / 2 - 1);
  localparam logic [CW-1:0] T_STP2  = CW'(2 * OVS - 1);

  uart_state_e           state_q, state_d;
  logic [CW-1:0]         tick_q, tick_d;
  logic [3:0]            bit_q, bit_d;
  logic [MAX_DATA_W-1:0] data_q, data_d;
  logic [3:0]            len_q, len_d;
  logic [2:0]            par_q, par_d;
  logic                  stp_q, stp_d;
  logic                  msb_q, msb_d;
  logic                  rd_en_q, rd_en_d;
  logic                  tsr_empty_q, tsr_empty_d;
  logic                  tx_q, tx_d;

  logic          par_bit;
  logic          bit_end, stop_end, last_data, fetch, line;
  logic [CW-1:0] stop_last;
  logic [3:0]    bit_idx;
  logic [15:0]   data_ext;

  uart_parity_gen #(.W(MAX_DATA_W)) u_par (
    .data_i (data_q),
    .len_i  (len_q),
    .mode_i (par_q),
    .par_o  (par_bit)
  );

  always_comb begin
    bit_end   = tick_q == T_BIT;
    stop_last = (stp_q == STP_TWO) ? ((len_q == 4'd5) ? T_STP15 : T_STP2) : T_BIT;
    stop_end  = tick_q == stop_last;
    last_data = bit_q == len_q - 4'd1;
    // a fetch at the last stop tick chains the next frame with no idle gap
    fetch = !tx_fifo_empty_i && !brk_i &&
            (state_q == ST_IDLE || (state_q == ST_STOP && tx_clk_en_i && stop_end));
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    data_d  = data_q;
    len_d   = len_q;
    par_d   = par_q;
    stp_d   = stp_q;
    msb_d   = msb_q;
    if (fetch) begin
      state_d = ST_START;
      tick_d  = '0;
      bit_d   = '0;
      data_d  = tx_fifo_data_i;
      len_d   = clamp_len(data_len_i, 4'(MAX_DATA_W));
      par_d   = par_mode_i;
      stp_d   = stp_bits_i;
      msb_d   = msb_first_i;
    end else if (tx_clk_en_i) begin
      case (state_q)
        ST_START: begin
          tick_d  = bit_end ? '0 : tick_q + CW'(1);
          state_d = bit_end ? ST_DATA : ST_START;
        end
        ST_DATA: begin
          tick_d  = bit_end ? '0 : tick_q + CW'(1);
          bit_d   = (bit_end && !last_data) ? bit_q + 4'd1 : (bit_end ? 4'd0 : bit_q);
          state_d = (bit_end && last_data) ? (par_q[0] ? ST_PARITY : ST_STOP) : ST_DATA;
        end
        ST_PARITY: begin
          tick_d  = bit_end ? '0 : tick_q + CW'(1);
          state_d = bit_end ? ST_STOP : ST_PARITY;
        end
        ST_STOP: begin
          tick_d  = stop_end ? '0 : tick_q + CW'(1);
          state_d = stop_end ? ST_IDLE : ST_STOP;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    // the line level is derived from the next state so it changes together with it
    bit_idx  = msb_q ? len_q - 4'd1 - bit_d : bit_d;
    data_ext = 16'(data_q);
    line = (state_d == ST_START)  ? 1'b0 :
           (state_d == ST_DATA)   ? data_ext[bit_idx] :
           (state_d == ST_PARITY) ? par_bit : 1'b1;
    tx_d        = !brk_i && line;
    rd_en_d     = fetch;
    tsr_empty_d = state_d == ST_IDLE;
  end

  always_ff @(posedge uart_clk_i or posedge uart_rst_i) begin
    if (uart_rst_i) begin
      state_q     <= ST_IDLE;
      tick_q      <= '0;
      bit_q       <= '0;
      data_q      <= '0;
      len_q       <= 4'd5;
      par_q       <= PAR_NONE;
      stp_q       <= STP_ONE;
      msb_q       <= 1'b0;
      rd_en_q     <= 1'b0;
      tsr_empty_q <= 1'b1;
      tx_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      data_q      <= data_d;
      len_q       <= len_d;
      par_q       <= par_d;
      stp_q       <= stp_d;
      msb_q       <= msb_d;
      rd_en_q     <= rd_en_d;
      tsr_empty_q <= tsr_empty_d;
      tx_q        <= tx_d;
    end
  end

  assign tx_fifo_rd_en_o = rd_en_q;
  assign tsr_empty_o     = tsr_empty_q;
  assign uart_tx_o       = tx_q;
endmodule

// File: tb/tb_uart_tx_ext.sv
// tb_uart_tx_ext: directed self-checking bench for uart_tx_ext
module tb_uart_tx_ext;
  localparam int OVS = 16;
  logic       clk = 1'b0, rst = 1'b1, en = 1'b0, empty = 1'b1, brk = 1'b0;
  logic       stp = 1'b0, msb = 1'b0;
  logic [8:0] fdata = '0;
  logic [3:0] len = 4'd8;
  logic [2:0] par = 3'b000;
  logic       rd_en, tsr_empty, tx;
  int         checks = 0, failures = 0, rd_cnt = 0, r_save;
  bit         tick_on = 1'b1;

  always #5 clk = ~clk;

  initial begin
    int c;
    c = 0;
    forever begin
      @(negedge clk);
      c = (c + 1) % 4;
      en = tick_on && (c == 0);
    end
  end

  always @(negedge clk) if (rd_en === 1'b1) rd_cnt++;

  uart_tx_ext #(.MAX_DATA_W(9), .OVS(OVS)) dut (
    .uart_clk_i      (clk),
    .uart_rst_i      (rst),
    .tx_clk_en_i     (en),
    .tx_fifo_data_i  (fdata),
    .tx_fifo_empty_i (empty),
    .tx_fifo_rd_en_o (rd_en),
    .data_len_i      (len),
    .par_mode_i      (par),
    .stp_bits_i      (stp),
    .msb_first_i     (msb),
    .brk_i           (brk),
    .tsr_empty_o     (tsr_empty),
    .uart_tx_o       (tx)
  );

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      int g;
      g = 0;
      @(posedge clk);
      while (!en && g < 100) begin
        @(posedge clk);
        g++;
      end
      if (g >= 100) begin
        checks++;
        failures++;
        $display("FAIL tick_timeout: got no tick want tick");
      end
    end
    #1;
  endtask

  task automatic kick(input logic [8:0] d, input logic [3:0] l, input logic [2:0] p,
                      input logic s, input logic m);
    fdata = d; len = l; par = p; stp = s; msb = m; empty = 1'b0;
    for (int g = 0; g < 20 && rd_en !== 1'b1; g++) begin
      @(posedge clk);
      #1;
    end
    chk(rd_en, 1, "fetch_pulse");
    chk(tx, 0, "fetch_start_low");
  endtask

  // bits are written in line order: bits[nb-1] is the start bit
  task automatic frame(input logic [11:0] bits, input int nb, input int stop_t,
                       input bit nxt_valid, input logic [8:0] nxt, input string tag);
    int r0;
    r0 = rd_cnt;
    empty = !nxt_valid;
    fdata = nxt;
    if (!nxt_valid) begin
      len = 4'd3; par = 3'b110; stp = ~stp; msb = ~msb;
    end
    for (int k = 0; k < nb; k++) begin
      chk(tx, bits[nb-1-k], $sformatf("%s_bit%0d_start", tag, k));
      chk(tsr_empty, 0, $sformatf("%s_bit%0d_busy", tag, k));
      wait_ticks(OVS - 1);
      chk(tx, bits[nb-1-k], $sformatf("%s_bit%0d_end", tag, k));
      wait_ticks(1);
    end
    chk(tx, 1, $sformatf("%s_stop_start", tag));
    wait_ticks(stop_t - 1);
    chk(tx, 1, $sformatf("%s_stop_end", tag));
    chk(tsr_empty, 0, $sformatf("%s_stop_busy", tag));
    wait_ticks(1);
    chk(rd_cnt - r0, 1, $sformatf("%s_one_pop", tag));
    if (nxt_valid) begin
      chk(tx, 0, $sformatf("%s_b2b_start", tag));
      chk(rd_en, 1, $sformatf("%s_b2b_pop", tag));
      chk(tsr_empty, 0, $sformatf("%s_b2b_busy", tag));
    end else begin
      chk(tx, 1, $sformatf("%s_idle_line", tag));
      chk(rd_en, 0, $sformatf("%s_idle_nopop", tag));
      @(posedge clk);
      #1;
      chk(tsr_empty, 1, $sformatf("%s_idle_empty", tag));
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk(tx, 1, "rst_tx");
    chk(tsr_empty, 1, "rst_tsr_empty");
    chk(rd_en, 0, "rst_rd_en");
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk(tsr_empty, 1, "idle_empty_fifo");

    kick(9'h023, 4'd8, 3'b000, 1'b0, 1'b0);
    frame(12'b0_11000100, 9, 16, 1'b0, 9'h000, "t8n1");

    kick(9'h023, 4'd7, 3'b011, 1'b1, 1'b0);
    frame(12'b0_1100010_1, 9, 32, 1'b0, 9'h000, "t7e2");

    kick(9'h023, 4'd8, 3'b001, 1'b0, 1'b0);
    frame(12'b0_11000100_0, 10, 16, 1'b0, 9'h000, "t8o1");

    kick(9'h023, 4'd5, 3'b101, 1'b1, 1'b0);
    frame(12'b0_11000_1, 7, 24, 1'b0, 9'h000, "t5m15");

    kick(9'h1A5, 4'd9, 3'b111, 1'b0, 1'b1);
    frame(12'b0_110100101_0, 11, 16, 1'b0, 9'h000, "t9s_msb");

    kick(9'h055, 4'd8, 3'b000, 1'b0, 1'b0);
    frame(12'b0_10101010, 9, 16, 1'b1, 9'h0AA, "b2b_a");
    frame(12'b0_01010101, 9, 16, 1'b0, 9'h000, "b2b_b");

    kick(9'h0FF, 4'd8, 3'b000, 1'b0, 1'b0);
    empty = 1'b1;
    wait_ticks(OVS + 3);
    chk(tx, 1, "brk_before");
    brk = 1'b1;
    @(posedge clk);
    #1;
    chk(tx, 0, "brk_next_cycle");
    wait_ticks(200);
    chk(tx, 0, "brk_held");
    chk(tsr_empty, 1, "brk_frame_done");
    r_save = rd_cnt;
    fdata = 9'h011;
    empty = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk(rd_cnt - r_save, 0, "brk_no_fetch");
    empty = 1'b1;
    brk = 1'b0;
    @(posedge clk);
    #1;
    chk(tx, 1, "brk_release");

    kick(9'h055, 4'd8, 3'b000, 1'b0, 1'b0);
    empty = 1'b1;
    wait_ticks(OVS + 2);
    chk(tx, 1, "stall_bit0");
    tick_on = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    chk(tx, 1, "stall_hold");
    chk(tsr_empty, 0, "stall_busy");
    tick_on = 1'b1;
    wait_ticks(OVS);
    chk(tx, 0, "rst_pre_bit1");
    rst = 1'b1;
    #2;
    chk(tx, 1, "arst_tx");
    chk(tsr_empty, 1, "arst_tsr_empty");
    chk(rd_en, 0, "arst_rd_en");
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk(tx, 1, "post_rst_idle");
    chk(tsr_empty, 1, "post_rst_empty");

    kick(9'h023, 4'd8, 3'b000, 1'b0, 1'b0);
    frame(12'b0_11000100, 9, 16, 1'b0, 9'h000, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
